vc_output_requester: RTL and testbench



---
 rtl/vc_output_requester_if.sv | 54 +++++
 rtl/vc_output_requester.sv | 133 +++++++++++++
 tb/tb_vc_output_requester.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_output_requester_if.sv
// Bundle between one input channel's flit FIFO, the four output-port arbiters
// and the crossbar, as seen by the VC output requester.
interface vc_output_requester_if #(
  parameter int FLIT_W = 8
);
  logic              fifo_empty;
  logic [FLIT_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              req1;
  logic              req2;
  logic              req3;
  logic              req4;
  logic              gnt1;
  logic              gnt2;
  logic              gnt3;
  logic              gnt4;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid;
  logic              busy;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  gnt1,
    input  gnt2,
    input  gnt3,
    input  gnt4,
    output fifo_rd,
    output req1,
    output req2,
    output req3,
    output req4,
    output flit_out,
    output flit_valid,
    output busy
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output gnt1,
    output gnt2,
    output gnt3,
    output gnt4,
    input  fifo_rd,
    input  req1,
    input  req2,
    input  req3,
    input  req4,
    input  flit_out,
    input  flit_valid,
    input  busy
  );
endinterface

// File: rtl/vc_output_requester.sv
// Requests the output port addressed by the head flit, streams the whole
// packet to the crossbar once granted, then releases the request.
//
// state   | meaning
// IDLE    | waiting for a header flit at the FIFO head
// REQ     | req[dest] high, waiting for gnt[dest]
// SEND    | popping header and body flits while granted and FIFO non-empty
// RELEASE | all req low, waiting for gnt[dest] to drop
module vc_output_requester #(
  parameter int FLIT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  vc_output_requester_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        dest_q, dest_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              hdr_sent_q, hdr_sent_d;
  logic [3:0]        req_q, req_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              flit_valid_q, flit_valid_d;

  logic [3:0] gnt_vec;
  logic       gnt_sel;
  logic       pop;

  assign gnt_vec = {bus.gnt4, bus.gnt3, bus.gnt2, bus.gnt1};
  assign gnt_sel = gnt_vec[dest_q];

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    cnt_d        = cnt_q;
    hdr_sent_d   = hdr_sent_q;
    flit_d       = flit_q;
    flit_valid_d = 1'b0;
    pop          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.fifo_empty) begin
          dest_d     = bus.fifo_data[1:0];
          cnt_d      = bus.fifo_data[5:2];
          hdr_sent_d = 1'b0;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        if (gnt_sel) begin
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (gnt_sel && !bus.fifo_empty) begin
          pop          = 1'b1;
          flit_d       = bus.fifo_data;
          flit_valid_d = 1'b1;
          if (!hdr_sent_q) begin
            hdr_sent_d = 1'b1;
            if (cnt_q == 4'd0) begin
              state_d = S_RELEASE;
            end
          end else begin
            // cnt counts body flits still to pop; the one taken at cnt==1 is the tail
            if (cnt_q <= 4'd1) begin
              state_d = S_RELEASE;
            end
            if (cnt_q != 4'd0) begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
      end

      S_RELEASE: begin
        hdr_sent_d = 1'b0;
        if (!gnt_sel) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered request follows the next state so it rises with REQ and drops with RELEASE
    if ((state_d == S_REQ) || (state_d == S_SEND)) begin
      req_d = 4'b0001 << dest_d;
    end else begin
      req_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dest_q       <= 2'd0;
      cnt_q        <= 4'd0;
      hdr_sent_q   <= 1'b0;
      req_q        <= 4'b0000;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      cnt_q        <= cnt_d;
      hdr_sent_q   <= hdr_sent_d;
      req_q        <= req_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
    end
  end

  assign bus.fifo_rd    = pop;
  assign bus.req1       = req_q[0];
  assign bus.req2       = req_q[1];
  assign bus.req3       = req_q[2];
  assign bus.req4       = req_q[3];
  assign bus.flit_out   = flit_q;
  assign bus.flit_valid = flit_valid_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_vc_output_requester.sv
// Randomized scoreboard bench for vc_output_requester: FIFO and arbiter models
// drive the DUT, a monitor checks the flit stream, request lines and gaps.
module tb_vc_output_requester;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_output_requester_if #(.FLIT_W(W)) bus ();
  vc_output_requester #(.FLIT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] data;
    bit           head;
    bit           tail;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fifo_q[$];
  exp_t         exp_flits[$];
  int           exp_pkt_dest[$];

  int stall_pct = 0;
  int drop_pct  = 0;
  int noise_pct = 0;
  int late_pct  = 0;
  bit clean     = 1'b1;
  bit flush     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_packet(input int dest, input int len);
    logic [W-1:0] h;
    exp_t e;
    h      = W'($urandom);
    h[1:0] = dest[1:0];
    h[5:2] = len[3:0];
    fifo_q.push_back(h);
    e.data = h; e.head = 1'b1; e.tail = (len == 0);
    exp_flits.push_back(e);
    exp_pkt_dest.push_back(dest);
    for (int i = 0; i < len; i++) begin
      e.data = W'($urandom); e.head = 1'b0; e.tail = (i == len - 1);
      fifo_q.push_back(e.data);
      exp_flits.push_back(e);
    end
  endtask

  function automatic logic [3:0] req_vec();
    return {bus.req4, bus.req3, bus.req2, bus.req1};
  endfunction

  // FIFO and arbiter models: sample DUT at negedge, update inputs 1ns after posedge
  initial begin
    logic       pop_now;
    logic [3:0] rq, gq, g;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    {bus.gnt4, bus.gnt3, bus.gnt2, bus.gnt1} = 4'b0000;
    forever begin
      @(negedge clk);
      pop_now = bus.fifo_rd;
      rq      = req_vec();
      gq      = {bus.gnt4, bus.gnt3, bus.gnt2, bus.gnt1};
      @(posedge clk);
      #1;
      if (reset) begin
        g = 4'b0000;
      end else begin
        if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
        for (int p = 0; p < 4; p++) begin
          if (rq[p])      g[p] = ($urandom_range(99) >= drop_pct);
          else if (gq[p]) g[p] = ($urandom_range(99) < late_pct);
          else            g[p] = ($urandom_range(99) < noise_pct);
        end
      end
      {bus.gnt4, bus.gnt3, bus.gnt2, bus.gnt1} = g;
      bus.fifo_empty = (fifo_q.size() == 0) || ($urandom_range(99) < stall_pct);
      bus.fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : W'($urandom);
    end
  end

  // Monitor: scoreboard pops on every flit_valid cycle
  initial begin
    int   gap = 0;
    bit   seen_tail = 1'b0;
    bit   prev_valid = 1'b0;
    exp_t e;
    logic [3:0] r;
    forever begin
      @(negedge clk);
      if (reset || flush) begin
        seen_tail  = 1'b0;
        prev_valid = 1'b0;
        gap        = 0;
        continue;
      end
      r = req_vec();
      if (r != 4'b0000) begin
        if (exp_pkt_dest.size() == 0) chk("req_without_packet", {28'd0, r}, 32'd0);
        else                          chk("req_dest", {28'd0, r}, 32'd1 << exp_pkt_dest[0]);
        chk("busy_while_req", {31'd0, bus.busy}, 32'd1);
      end
      if (bus.fifo_rd) chk("pop_when_empty", {31'd0, bus.fifo_empty}, 32'd0);
      if (bus.flit_valid) begin
        if (exp_flits.size() == 0) begin
          chk("unexpected_flit", {24'd0, bus.flit_out}, 32'hffff_ffff);
        end else begin
          e = exp_flits.pop_front();
          chk("flit_data", {24'd0, bus.flit_out}, {24'd0, e.data});
          if (e.head && seen_tail) begin
            checks++;
            if (gap < 2) begin
              errors++;
              $display("FAIL tail_to_header_gap actual=%0d required>=2 at %0t", gap, $time);
            end
          end
          if (!e.head && clean) chk("best_case_no_bubble", {31'd0, prev_valid}, 32'd1);
          if (e.tail) begin
            if (exp_pkt_dest.size() > 0) void'(exp_pkt_dest.pop_front());
            seen_tail = 1'b1;
            gap       = 0;
          end
        end
      end else begin
        gap++;
      end
      prev_valid = bus.flit_valid;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req"},        {28'd0, req_vec()}, 32'd0);
    chk({tag, "_flit_valid"}, {31'd0, bus.flit_valid}, 32'd0);
    chk({tag, "_busy"},       {31'd0, bus.busy}, 32'd0);
    chk({tag, "_fifo_rd"},    {31'd0, bus.fifo_rd}, 32'd0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_flits.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining_flits", exp_flits.size(), 32'd0);
    if (exp_flits.size() != 0) begin
      fifo_q.delete();
      exp_flits.delete();
      exp_pkt_dest.delete();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_flit_out", {24'd0, bus.flit_out}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Clean grants, no FIFO bubbles: dest 1 LEN 2, dest 3 LEN 0, then random
    clean = 1'b1;
    push_packet(1, 2);
    push_packet(3, 0);
    for (int i = 0; i < 6; i++) push_packet(int'($urandom_range(3)), int'($urandom_range(15)));
    wait_drain(2000);
    repeat (4) @(negedge clk);
    check_idle_outputs("after_clean");

    // FIFO bubbles, grant drops, late grant release and spurious grants
    clean     = 1'b0;
    stall_pct = 30;
    drop_pct  = 20;
    noise_pct = 10;
    late_pct  = 50;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (fifo_q.size() > 24 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      push_packet(int'($urandom_range(3)), int'($urandom_range(15)));
    end
    noise_pct = 0;
    wait_drain(20000);
    late_pct = 0;
    repeat (6) @(negedge clk);
    check_idle_outputs("after_random");

    // Reset mid-SEND of a LEN 15 packet
    stall_pct = 0;
    drop_pct  = 0;
    push_packet(int'($urandom_range(3)), 15);
    n = 0;
    while (exp_flits.size() > 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_mid_packet", {31'd0, bus.busy}, 32'd1);
    #2;
    flush = 1'b1;
    reset = 1'b1;
    fifo_q.delete();
    exp_flits.delete();
    exp_pkt_dest.delete();
    #1;
    check_idle_outputs("async_reset");
    chk("async_reset_flit_out", {24'd0, bus.flit_out}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fifo_rd_in_reset", {31'd0, bus.fifo_rd}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    flush = 1'b0;

    // Recovery after abandoned packet
    clean = 1'b1;
    push_packet(2, 5);
    push_packet(0, 3);
    wait_drain(2000);
    repeat (4) @(negedge clk);
    check_idle_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
